// File: rtl/echo_app_active_q_if.sv
// Handshake bundle between the flow-ID active queue, its setup/teardown notifiers
// and echo_app_rx_msg_if. The slave modport is the queue side.
interface echo_app_active_q_if #(
    parameter int FLOWID_W = 7
);
    logic                new_flow_active_q_val;
    logic [FLOWID_W-1:0] new_flow_active_q_flowid;
    logic                active_q_new_flow_rdy;
    logic                flow_close_active_q_val;
    logic [FLOWID_W-1:0] flow_close_active_q_flowid;
    logic                active_q_msg_if_empty;
    logic                msg_if_active_q_rd_req;
    logic [FLOWID_W-1:0] active_q_msg_if_rd_data;
    logic                msg_if_active_q_wr_req;
    logic [FLOWID_W-1:0] msg_if_active_q_wr_data;
    logic                active_q_msg_if_wr_rdy;

    modport slave (
        input  new_flow_active_q_val, new_flow_active_q_flowid,
        input  flow_close_active_q_val, flow_close_active_q_flowid,
        input  msg_if_active_q_rd_req, msg_if_active_q_wr_req, msg_if_active_q_wr_data,
        output active_q_new_flow_rdy, active_q_msg_if_empty, active_q_msg_if_rd_data,
        output active_q_msg_if_wr_rdy
    );

    modport master (
        output new_flow_active_q_val, new_flow_active_q_flowid,
        output flow_close_active_q_val, flow_close_active_q_flowid,
        output msg_if_active_q_rd_req, msg_if_active_q_wr_req, msg_if_active_q_wr_data,
        input  active_q_new_flow_rdy, active_q_msg_if_empty, active_q_msg_if_rd_data,
        input  active_q_msg_if_wr_rdy
    );
endinterface

// File: rtl/echo_app_active_q.sv
// Active-flow scheduling queue: one slot per flow ID, closed flows are skipped at the head.
// Optional statistics counters are enabled with the ECHO_ACTIVE_Q_STATS_EN macro.
module echo_app_active_q #(
    parameter int FLOWID_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    echo_app_active_q_if.slave   q
`ifdef ECHO_ACTIVE_Q_STATS_EN
    ,
    output logic [31:0]          active_q_stat_dup_drops,
    output logic [31:0]          active_q_stat_stale_discards,
    output logic [FLOWID_W:0]    active_q_stat_high_water
`endif
);
    localparam int DEPTH = 2 ** FLOWID_W;
    localparam logic [FLOWID_W:0] FULL = (FLOWID_W + 1)'(DEPTH);

    logic [FLOWID_W-1:0] mem_q [DEPTH];
    logic [FLOWID_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [FLOWID_W:0]   count_q, count_d;
    logic [DEPTH-1:0]    inq_q, inq_d, open_q, open_d;
    logic [FLOWID_W-1:0] head_id, enq_id;
    logic                stale, empty, pop, deq, enq, req_inq, closing;

    always_comb begin
        head_id = mem_q[head_q];
        stale   = (count_q != '0) && !open_q[head_id];
        empty   = (count_q == '0) || stale;
        pop     = q.msg_if_active_q_rd_req && !empty;
        deq     = pop || stale;

        enq     = 1'b0;
        enq_id  = '0;
        req_inq = 1'b0;
        closing = 1'b0;
        open_d  = open_q;
        inq_d   = inq_q;

        // Requeue wins the single write slot; a flow popped this cycle may be requeued at once.
        if (q.msg_if_active_q_wr_req) begin
            enq_id  = q.msg_if_active_q_wr_data;
            closing = q.flow_close_active_q_val && (q.flow_close_active_q_flowid == enq_id);
            req_inq = inq_q[enq_id] && !(pop && (head_id == enq_id));
            enq     = open_q[enq_id] && !req_inq && !closing;
        end else if (q.new_flow_active_q_val) begin
            enq_id  = q.new_flow_active_q_flowid;
            closing = q.flow_close_active_q_val && (q.flow_close_active_q_flowid == enq_id);
            if (!closing) begin
                open_d[enq_id] = 1'b1;
                enq            = !inq_q[enq_id];
            end
        end

        if (q.flow_close_active_q_val) open_d[q.flow_close_active_q_flowid] = 1'b0;
        if (deq) inq_d[head_id] = 1'b0;
        if (enq) inq_d[enq_id] = 1'b1;

        head_d  = head_q + FLOWID_W'(deq);
        tail_d  = tail_q + FLOWID_W'(enq);
        count_d = count_q + (FLOWID_W + 1)'(enq) - (FLOWID_W + 1)'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            inq_q   <= '0;
            open_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            inq_q   <= inq_d;
            open_q  <= open_d;
        end
    end

    // Storage needs no reset: count and the bitmaps decide what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && enq) mem_q[tail_q] <= enq_id;
    end

    assign q.active_q_msg_if_empty   = empty;
    assign q.active_q_msg_if_rd_data = empty ? '0 : head_id;
    assign q.active_q_msg_if_wr_rdy  = rst_n;
    assign q.active_q_new_flow_rdy   = rst_n & ~q.msg_if_active_q_wr_req;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !deq && (count_q == FULL)))
        else $fatal(1, "echo_app_active_q: enqueue with queue full");

`ifdef ECHO_ACTIVE_Q_STATS_EN
    logic [31:0]       dup_q, dup_d, stale_cnt_q, stale_cnt_d;
    logic [FLOWID_W:0] hw_q, hw_d;
    logic              dup_drop;

    // Any write-port attempt that did not land in the queue is a drop.
    always_comb begin
        dup_drop    = (q.msg_if_active_q_wr_req || q.new_flow_active_q_val) && !enq;
        dup_d       = dup_q + 32'(dup_drop && (dup_q != '1));
        stale_cnt_d = stale_cnt_q + 32'(stale && (stale_cnt_q != '1));
        hw_d        = (count_q > hw_q) ? count_q : hw_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_q       <= '0;
            stale_cnt_q <= '0;
            hw_q        <= '0;
        end else begin
            dup_q       <= dup_d;
            stale_cnt_q <= stale_cnt_d;
            hw_q        <= hw_d;
        end
    end

    assign active_q_stat_dup_drops      = dup_q;
    assign active_q_stat_stale_discards = stale_cnt_q;
    assign active_q_stat_high_water     = hw_q;
`endif
endmodule

// File: tb/tb_echo_app_active_q.sv
// Scoreboard bench for echo_app_active_q: a flow-level queue model predicts every
// cycle's flags and every popped flow ID; a separate monitor compares them.
module tb_echo_app_active_q;
    localparam int FLOWID_W = 7;
    localparam int NFLOWS   = 2 ** FLOWID_W;

    typedef struct {
        bit empty;
        bit new_rdy;
        bit wr_rdy;
    } exp_t;

    logic clk;
    logic rst_n;
    echo_app_active_q_if #(.FLOWID_W(FLOWID_W)) bus ();

    echo_app_active_q #(.FLOWID_W(FLOWID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   data_q[$];

    // Reference model: an ordered list of queued flows plus open/queued sets.
    int   fifo[$];
    bit   open_m[NFLOWS];
    bit   inq_m[NFLOWS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        fifo.delete();
        for (int i = 0; i < NFLOWS; i++) begin
            open_m[i] = 1'b0;
            inq_m[i]  = 1'b0;
        end
    endtask

    // One cycle of stimulus; the model predicts this cycle's outputs and next state.
    task automatic applyStimulus(input bit nv, input int nid, input bit cv, input int cid,
                                 input bit rd, input bit wr, input int wid);
        exp_t e;
        bit   stale, emp, pop, enq;
        int   head, f;
        @(posedge clk);
        #1;
        bus.new_flow_active_q_val      = nv;
        bus.new_flow_active_q_flowid   = FLOWID_W'(nid);
        bus.flow_close_active_q_val    = cv;
        bus.flow_close_active_q_flowid = FLOWID_W'(cid);
        bus.msg_if_active_q_rd_req     = rd;
        bus.msg_if_active_q_wr_req     = wr;
        bus.msg_if_active_q_wr_data    = FLOWID_W'(wid);

        head  = (fifo.size() > 0) ? fifo[0] : -1;
        stale = (fifo.size() > 0) && !open_m[head];
        emp   = (fifo.size() == 0) || stale;
        pop   = rd && !emp;
        e.empty   = emp;
        e.new_rdy = !wr;
        e.wr_rdy  = 1'b1;
        exp_q.push_back(e);
        if (pop) data_q.push_back(head);

        enq = 1'b0;
        f   = 0;
        if (wr) begin
            f = wid;
            if (open_m[f] && !(inq_m[f] && !(pop && head == f)) && !(cv && cid == f)) enq = 1'b1;
        end else if (nv) begin
            f = nid;
            if (!(cv && cid == f)) begin
                open_m[f] = 1'b1;
                enq       = !inq_m[f];
            end
        end
        if (cv) open_m[cid] = 1'b0;
        if (pop || stale) begin
            fifo.delete(0);
            inq_m[head] = 1'b0;
        end
        if (enq) begin
            fifo.push_back(f);
            inq_m[f] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic popN(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: compares flags every cycle and the flow ID on every accepted pop.
    initial begin
        exp_t e;
        int   want;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("empty", int'(bus.active_q_msg_if_empty), int'(e.empty));
                checkOutput("new_flow_rdy", int'(bus.active_q_new_flow_rdy), int'(e.new_rdy));
                checkOutput("wr_rdy", int'(bus.active_q_msg_if_wr_rdy), int'(e.wr_rdy));
                if (bus.active_q_msg_if_empty)
                    checkOutput("rd_data_idle", int'(bus.active_q_msg_if_rd_data), 0);
                else if (bus.msg_if_active_q_rd_req) begin
                    if (data_q.size() == 0) begin
                        checkOutput("pop_unexpected", int'(bus.active_q_msg_if_rd_data), -1);
                    end else begin
                        want = data_q.pop_front();
                        checkOutput("pop_data", int'(bus.active_q_msg_if_rd_data), want);
                    end
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_empty"}, int'(bus.active_q_msg_if_empty), 1);
        checkOutput({tag, "_rd_data"}, int'(bus.active_q_msg_if_rd_data), 0);
        checkOutput({tag, "_new_rdy"}, int'(bus.active_q_new_flow_rdy), 0);
        checkOutput({tag, "_wr_rdy"}, int'(bus.active_q_msg_if_wr_rdy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.new_flow_active_q_val      = 1'b0;
        bus.new_flow_active_q_flowid   = '0;
        bus.flow_close_active_q_val    = 1'b0;
        bus.flow_close_active_q_flowid = '0;
        bus.msg_if_active_q_rd_req     = 1'b0;
        bus.msg_if_active_q_wr_req     = 1'b0;
        bus.msg_if_active_q_wr_data    = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("release_new_rdy", int'(bus.active_q_new_flow_rdy), 1);
        checkOutput("release_wr_rdy", int'(bus.active_q_msg_if_wr_rdy), 1);

        $display("[TB] directed: back-to-back new flows");
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 0, 0, 0);
        popN(4);

        $display("[TB] directed: duplicate announce");
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        popN(2);

        $display("[TB] directed: requeue beats new flow");
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        popN(2);
        applyStimulus(1, 7, 0, 0, 0, 1, 2);
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        popN(3);

        $display("[TB] directed: closed flow skipped at head");
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 6, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        popN(3);

        $display("[TB] directed: pop and requeue same flow");
        applyStimulus(1, 8, 0, 0, 0, 0, 0);
        applyStimulus(1, 10, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 8);
        popN(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(1, 0) == 1, $urandom_range(15, 0),
                          $urandom_range(7, 0) == 0, $urandom_range(15, 0),
                          $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
                          $urandom_range(15, 0));
        end
        popN(60);
        #1;
        checkOutput("drained_empty", int'(bus.active_q_msg_if_empty), 1);

        $display("[TB] fill every flow then reset mid-stream");
        for (int i = 0; i < NFLOWS; i++) applyStimulus(1, i, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("full_not_empty", int'(bus.active_q_msg_if_empty), 0);
        @(posedge clk);
        #1;
        bus.new_flow_active_q_val    = 1'b1;
        bus.new_flow_active_q_flowid = FLOWID_W'(0);
        bus.msg_if_active_q_rd_req   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        bus.new_flow_active_q_val  = 1'b0;
        bus.msg_if_active_q_rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
        idle(3);
        popN(3);
        @(negedge clk);
        #1;
        checkOutput("post_reset_empty", int'(bus.active_q_msg_if_empty), 1);
        checkOutput("pending_flags", exp_q.size(), 0);
        checkOutput("pending_pops", data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_app_active_q.md
Name: echo_app_active_q

Overview:
- Flow-ID scheduling queue that feeds echo_app_rx_msg_if. It supplies the next active flow on the read port and takes back re-armed flows on the requeue port.
- New flows arrive from the connection-setup notifier; closed flows are retired by the teardown notifier.
- Each open flow appears in the queue at most once, so the queue can never overflow. Entries for closed flows are discarded internally and never reach the consumer.

Parameters:
- FLOWID_W, 7: flow-ID width. Queue depth is 2**FLOWID_W entries, one slot per flow ID.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- new_flow_active_q_val  in  1  new-flow enqueue valid
- new_flow_active_q_flowid  in  FLOWID_W  new flow ID
- active_q_new_flow_rdy  out  1  new-flow enqueue ready
- flow_close_active_q_val  in  1  flow teardown strobe; always accepted
- flow_close_active_q_flowid  in  FLOWID_W  flow ID being closed
- active_q_msg_if_empty  out  1  no deliverable head entry
- msg_if_active_q_rd_req  in  1  pop the head entry
- active_q_msg_if_rd_data  out  FLOWID_W  head flow ID (first-word fall-through)
- msg_if_active_q_wr_req  in  1  requeue valid
- msg_if_active_q_wr_data  in  FLOWID_W  requeued flow ID
- active_q_msg_if_wr_rdy  out  1  requeue ready

Behaviour:
- State:
  - Flop array mem[2**FLOWID_W].
  - head/tail pointers of FLOWID_W bits, wrapping naturally mod depth.
  - count of FLOWID_W+1 bits.
  - Bitmaps in_q[f] and open[f].
- Reset (rst_n low, asynchronous): pointers, count and both bitmaps are cleared. Outputs: empty=1, rd_data=0, both rdy=0. In the first cycle after release, both rdy=1.
- Write port arbitration (one write per cycle):
  - Requeue has priority.
  - active_q_msg_if_wr_rdy=1 whenever out of reset.
  - active_q_new_flow_rdy = !msg_if_active_q_wr_req.
- New-flow accept sets open[f]:
  - If in_q[f]=0: write mem[tail], tail++, count++, set in_q[f].
  - If in_q[f]=1: open is set, no write.
- Requeue accept:
  - If open[f]=1 and in_q[f]=0: enqueue as above.
  - Otherwise drop silently.
  - The in_q check uses the same-cycle pop bypass: if the head being popped equals f, it counts as in_q=0, so the requeue is accepted.
- Close: clears open[f] at the clock edge. Close beats a same-cycle new-flow or requeue of the same f: the enqueue is dropped and open stays 0. in_q[f] is untouched.
- Stale head: count>0 and open[mem[head]]=0.
  - empty forced 1.
  - Head discarded internally that cycle: head++, count--, clear in_q.
  - Any rd_req that cycle is ignored.
  - One stale entry is removed per cycle.
- Output rules:
  - empty = (count==0) | stale head.
  - rd_data = mem[head] when !empty, else 0.
- Pop: rd_req && !empty → head++, count--, clear in_q[head]. rd_req while empty is ignored with no state change.
- Latency: a write into an empty queue deasserts empty on the following cycle.
- Simultaneous pop and enqueue: count unchanged; pointers both advance.
- count never exceeds 2**FLOWID_W. An enqueue attempted with count full is a fatal assertion in simulation.
- Reset mid-operation: all queued flows are lost; the upstream must re-announce them.

Optional Feature:
- Macro: ECHO_ACTIVE_Q_STATS_EN.
- When defined, adds output ports, all reset to 0 and all saturating:
  - active_q_stat_dup_drops (32-bit): duplicate and closed-flow drops.
  - active_q_stat_stale_discards (32-bit): internal stale-head discards.
  - active_q_stat_high_water (FLOWID_W+1 bit): maximum count observed.
- When undefined: the ports and logic are absent; queue behaviour is identical.

Test Plan:
- New flows 3, 5, 9 on consecutive cycles → empty drops 1 cycle after the first accept; pops return 3, 5, 9; empty=1 after the third pop.
- New flow 4 twice while still queued → one entry; count=1; dup_drops=1 with the stats macro.
- New flow 7 at the same time as requeue 2 (2 open) → new_flow_rdy=0 that cycle; 2 is enqueued first, 7 on the next cycle; pop order 2, 7.
- Queue 1, 6, then close 1 → empty=1 for one cycle while 1 is discarded; the next read returns 6; stale_discards=1.
- Pop 8 and requeue 8 in the same cycle → accepted; count unchanged; 8 is the next head once the others drain.
- Fill all 128 flows (FLOWID_W=7), drop rst_n mid-stream → outputs at reset values immediately; after release empty=1 and count=0.
